// File: rtl/jtframe_sdram_pkg.sv
// jtframe_sdram_pkg: shared state encoding and slot count for the SDRAM arbiter
package jtframe_sdram_pkg;
  localparam int SLOTS = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, BUSY = 2'd2} state_t;
endpackage

// File: rtl/jtframe_sdram_rrpick.sv
// jtframe_sdram_rrpick: round-robin pick among slots 1-3, starting after the last granted slot
module jtframe_sdram_rrpick (
  input  logic [3:1] req,
  input  logic [1:0] rr,
  output logic [1:0] idx,
  output logic       valid
);
  logic [1:0] s1, s2, s3;
  always_comb begin
    s1 = rr == 2'd1 ? 2'd2 : rr == 2'd2 ? 2'd3 : 2'd1;
    s2 = s1 == 2'd3 ? 2'd1 : s1 + 2'd1;
    s3 = s2 == 2'd3 ? 2'd1 : s2 + 2'd1;
    idx = req[s1] ? s1 : req[s2] ? s2 : s3;
    valid = |req;
  end
endmodule

// File: rtl/jtframe_sdram_arb.sv
// jtframe_sdram_arb: four-slot SDRAM request arbiter, slot 0 fixed priority, slots 1-3 round-robin
module jtframe_sdram_arb
  import jtframe_sdram_pkg::*;
#(
  parameter int AW   = 22,
  parameter int TOUT = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                downloading,
  input  logic [SLOTS-1:0]    slot_req,
  input  logic [SLOTS*AW-1:0] slot_addr,
  input  logic [SLOTS*2-1:0]  slot_bank,
  input  logic [SLOTS-1:0]    slot_rnw,
  input  logic [SLOTS*2-1:0]  slot_wrmask,
  input  logic [SLOTS*16-1:0] slot_din,
  output logic [SLOTS-1:0]    slot_ok,
  output logic [31:0]         slot_dout,
  output logic                timeout,
  output logic                read_req,
  output logic [AW-1:0]       sdram_addr,
  output logic [1:0]          sdram_bank,
  output logic                sdram_rnw,
  output logic [1:0]          sdram_wrmask,
  output logic [15:0]         data_write,
  output logic                refresh_en,
  input  logic                sdram_ack,
  input  logic                data_rdy,
  input  logic [31:0]         data_read
);
  state_t state, state_nxt;
  logic [1:0] rr, sel, rr_idx, grant;
  logic rr_valid, grant_ok, wd_end;
  logic [TOUT-1:0] wd;

  jtframe_sdram_rrpick u_rrpick (
    .req  (slot_req[3:1]),
    .rr   (rr),
    .idx  (rr_idx),
    .valid(rr_valid)
  );

  always_comb begin
    grant = slot_req[0] ? 2'd0 : rr_idx;
    grant_ok = !downloading && (slot_req[0] || rr_valid);
    wd_end = wd == {{(TOUT-1){1'b1}}, 1'b0};
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = grant_ok ? REQ : IDLE;
      REQ:     state_nxt = downloading ? IDLE : sdram_ack ? BUSY : REQ;
      BUSY:    state_nxt = downloading || data_rdy || wd_end ? IDLE : BUSY;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr           <= 2'd3;
      sel          <= 2'd0;
      wd           <= '0;
      read_req     <= 1'b0;
      slot_ok      <= '0;
      timeout      <= 1'b0;
      refresh_en   <= 1'b0;
      slot_dout    <= '0;
      sdram_addr   <= '0;
      sdram_bank   <= '0;
      sdram_rnw    <= 1'b1;
      sdram_wrmask <= '0;
      data_write   <= '0;
    end else begin
      slot_ok    <= '0;
      refresh_en <= state == IDLE && slot_req == '0 && !downloading;
      if (state == IDLE && grant_ok) begin
        sel          <= grant;
        read_req     <= 1'b1;
        sdram_addr   <= slot_addr[grant*AW +: AW];
        sdram_bank   <= slot_bank[grant*2 +: 2];
        sdram_rnw    <= slot_rnw[grant];
        sdram_wrmask <= slot_wrmask[grant*2 +: 2];
        data_write   <= slot_din[grant*16 +: 16];
        if (grant != 2'd0) rr <= grant;
      end
      if (state == REQ && (downloading || sdram_ack)) begin
        read_req <= 1'b0;
        wd       <= '0;
      end
      // an abort on downloading suppresses both completion and watchdog
      if (state == BUSY && !downloading) begin
        if (data_rdy) begin
          if (sdram_rnw) slot_dout <= data_read;
          slot_ok <= 4'd1 << sel;
        end else begin
          wd <= wd + 1'b1;
          if (wd_end) timeout <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_jtframe_sdram_arb.sv
// tb_jtframe_sdram_arb: randomized clients and controller against a protocol-level arbiter model
module tb_jtframe_sdram_arb;
  localparam int AW = 22;
  localparam int TOUT = 4;
  logic clk = 0, rst = 1, downloading = 0;
  logic [3:0] slot_req = 0, slot_rnw = 4'hf;
  logic [4*AW-1:0] slot_addr = 0;
  logic [7:0] slot_bank = 0, slot_wrmask = 0;
  logic [63:0] slot_din = 0;
  logic [3:0] slot_ok;
  logic [31:0] slot_dout, data_read = 0;
  logic timeout, read_req, sdram_rnw, refresh_en, sdram_ack = 0, data_rdy = 0;
  logic [AW-1:0] sdram_addr, e_addr;
  logic [1:0] sdram_bank, sdram_wrmask, e_bank, e_mask;
  logic [15:0] data_write, e_din;
  logic e_rnw;
  int errors = 0, checks = 0;
  int m = 0, cur = 0, rr_m = 3, acnt = 0, dcnt = 0, bc = 0, cyc = 0;
  int done_cnt [4] = '{0, 0, 0, 0};
  logic [31:0] dout_m = 0;
  logic tout_m = 0, exp_rd = 0, exp_ref = 0, gnt_chk = 0, withhold = 0, new_ok = 0, dir = 0;
  typedef struct {int slot; logic [31:0] dout;} comp_t;
  comp_t sb[$];

  always #5 clk = ~clk;

  jtframe_sdram_arb #(.AW(AW), .TOUT(TOUT)) dut (
    .clk(clk), .rst(rst), .downloading(downloading),
    .slot_req(slot_req), .slot_addr(slot_addr), .slot_bank(slot_bank),
    .slot_rnw(slot_rnw), .slot_wrmask(slot_wrmask), .slot_din(slot_din),
    .slot_ok(slot_ok), .slot_dout(slot_dout), .timeout(timeout),
    .read_req(read_req), .sdram_addr(sdram_addr), .sdram_bank(sdram_bank),
    .sdram_rnw(sdram_rnw), .sdram_wrmask(sdram_wrmask), .data_write(data_write),
    .refresh_en(refresh_en), .sdram_ack(sdram_ack), .data_rdy(data_rdy),
    .data_read(data_read)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // slot 0 first, otherwise the first requester after the last round-robin winner
  function automatic int pick(input logic [3:0] r, input int last);
    if (r[0]) return 0;
    for (int k = 1; k <= 3; k++)
      if (r[(last - 1 + k) % 3 + 1]) return (last - 1 + k) % 3 + 1;
    return -1;
  endfunction

  always @(negedge clk) begin
    comp_t c;
    if (!rst && slot_ok != 0) begin
      if (sb.size() == 0) chk("unexpected slot_ok", slot_ok, 0);
      else begin
        c = sb.pop_front();
        chk("slot_ok", slot_ok, 4'd1 << c.slot);
        chk("slot_dout", slot_dout, c.dout);
        done_cnt[c.slot]++;
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst read_req", read_req, 0);
    chk("rst slot_ok", slot_ok, 0);
    chk("rst timeout", timeout, 0);
    chk("rst refresh_en", refresh_en, 0);
    chk("rst slot_dout", slot_dout, 0);
    chk("rst sdram_addr", sdram_addr, 0);
    chk("rst data_write", data_write, 0);
    chk("rst sdram_rnw", sdram_rnw, 1);
    chk("rst sdram_wrmask", sdram_wrmask, 0);
    chk("rst sdram_bank", sdram_bank, 0);
    rst = 0;
    for (int c = 0; c < 3000; c++) begin
      cyc = c;
      dir = c < 40;
      new_ok = c >= 40 && c < 2900;
      withhold = c >= 1500 && c < 1560;
      for (int i = 0; i < 4; i++) begin
        if (slot_ok[i]) slot_req[i] = 0;
        else if (!slot_req[i] && !(m != 0 && cur == i) && ((new_ok && $urandom_range(0, 3) == 0) || (dir && c == 2 && i == 2))) begin
          slot_req[i] = 1;
          slot_addr[i*AW +: AW] = dir ? AW'(22'h1234) : AW'($urandom);
          slot_bank[i*2 +: 2] = 2'($urandom);
          slot_rnw[i] = dir ? 1'b1 : 1'($urandom);
          slot_wrmask[i*2 +: 2] = 2'($urandom);
          slot_din[i*16 +: 16] = 16'($urandom);
        end else if (slot_req[i] && !(m != 0 && cur == i) && !dir && $urandom_range(0, 40) == 0) slot_req[i] = 0;
      end
      if (c >= 700 && c < 1200) begin
        if ($urandom_range(0, 9) == 0) downloading = ~downloading;
      end else downloading = 0;
      sdram_ack = m == 1 && acnt == 0;
      if (m == 1 && acnt > 0) acnt--;
      data_rdy = m == 2 && dcnt == 0 && !withhold;
      if (m == 2 && dcnt > 0) dcnt--;
      data_read = dir ? 32'hDEADBEEF : $urandom;
      // protocol model: what the arbiter must do at the coming clock edge
      exp_ref = m == 0 && slot_req == 0 && !downloading;
      case (m)
        0: if (!downloading && slot_req != 0) begin
          cur = pick(slot_req, rr_m);
          if (cur != 0) rr_m = cur;
          e_addr = slot_addr[cur*AW +: AW];
          e_bank = slot_bank[cur*2 +: 2];
          e_rnw = slot_rnw[cur];
          e_mask = slot_wrmask[cur*2 +: 2];
          e_din = slot_din[cur*16 +: 16];
          gnt_chk = 1;
          acnt = dir ? 3 : $urandom_range(0, 4);
          m = 1;
        end
        1: if (downloading) m = 0;
           else if (sdram_ack) begin
             m = 2;
             bc = 0;
             dcnt = dir ? 4 : $urandom_range(0, 6);
           end
        default: if (downloading) m = 0;
           else if (data_rdy) begin
             if (e_rnw) dout_m = data_read;
             sb.push_back('{cur, dout_m});
             m = 0;
           end else begin
             bc++;
             if (bc == 2**TOUT - 1) begin
               tout_m = 1;
               m = 0;
             end
           end
      endcase
      exp_rd = m == 1;
      @(negedge clk);
      chk("read_req", read_req, exp_rd);
      chk("refresh_en", refresh_en, exp_ref);
      chk("timeout", timeout, tout_m);
      chk("slot_dout held", slot_dout, dout_m);
      if (gnt_chk) begin
        chk("sdram_addr", sdram_addr, e_addr);
        chk("sdram_bank", sdram_bank, e_bank);
        chk("sdram_rnw", sdram_rnw, e_rnw);
        chk("sdram_wrmask", sdram_wrmask, e_mask);
        chk("data_write", data_write, e_din);
        gnt_chk = 0;
      end
      if (c == 39) chk("directed slot2 dout", slot_dout, 32'hDEADBEEF);
    end
    chk("timeout reached", timeout, 1);
    chk("scoreboard drained", sb.size(), 0);
    for (int i = 0; i < 4; i++) chk("slot serviced", done_cnt[i] > 0, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/jtframe_sdram_arb.md
# jtframe_sdram_arb

Four-slot request arbiter sitting between game-side memory clients (CPU, graphics, sound ROM fetchers) and the single-port SDRAM controller. It latches one slot's address and command, drives the controller's `read_req`/`sdram_ack`/`data_rdy` handshake, and returns the 32-bit result to the granted slot with a one-cycle `slot_ok` pulse. Slot 0 has fixed top priority; slots 1–3 share round-robin. Refresh is only enabled when no work is pending.

## Interface
- `AW`, 22, word address width per slot, which equals the controller address width.
- `TOUT`, 8, width of the completion watchdog counter. Timeout is 2^TOUT−1 cycles.
- `clk`  in  1  clock; the same clock as the SDRAM controller.
- `rst`  in  1  reset, asynchronous, active-high.
- `downloading`  in  1  ROM load in progress; arbitration is frozen while high.
- `slot_req`  in  4  per-slot request level; held high until `slot_ok`.
- `slot_addr`  in  4*AW  packed addresses; slot n occupies `[n*AW+:AW]`.
- `slot_bank`  in  8  packed 2-bit banks.
- `slot_rnw`  in  4  1=read, 0=write.
- `slot_wrmask`  in  8  packed 2-bit write masks; active-high masking.
- `slot_din`  in  64  packed 16-bit write data.
- `slot_ok`  out  4  one-cycle completion pulse, one-hot.
- `slot_dout`  out  32  read data; valid with `slot_ok` and held until the next completion.
- `timeout`  out  1  sticky watchdog flag; cleared only by `rst`.
- `read_req`  out  1  request to the controller.
- `sdram_addr`, `sdram_bank`, `sdram_rnw`, `sdram_wrmask`, `data_write`  out  AW/2/1/2/16  latched command fields.
- `refresh_en`  out  1  refresh permission.
- `sdram_ack`  in  1  controller accepted the request.
- `data_rdy`  in  1  controller completion strobe, issued for both reads and writes.
- `data_read`  in  32  controller read data.

## Operation
- FSM states: IDLE, REQ, BUSY.
- **IDLE**
  - If `downloading`=1, stay in IDLE.
  - Otherwise, if any `slot_req` bit is set, choose the grant:
    - slot 0 if its request is set;
    - else the first requesting slot after `rr` in the order 1→2→3→1.
  - Latch the chosen slot's fields onto the `sdram_*` outputs, set `read_req`=1, record `sel`, go to REQ.
  - Update `rr` only when a slot 1–3 is granted.
- **REQ**
  - On `sdram_ack`=1: clear `read_req`, clear the watchdog, go to BUSY.
- **BUSY**
  - On `data_rdy`=1:
    - if `sdram_rnw`=1, capture `data_read` into `slot_dout`; if 0, leave `slot_dout` unchanged;
    - pulse `slot_ok[sel]`;
    - go to IDLE.
  - The watchdog increments each BUSY cycle. When it reaches all-ones: set `timeout`, go to IDLE with no `slot_ok`.
- **Abort:** `downloading` rising while in REQ or BUSY forces IDLE next cycle. `read_req` drops and no `slot_ok` is issued; the requester keeps `req` high and is regranted later.
- **Withdrawn requests:**
  - A `slot_req` dropped before grant is ignored.
  - A `slot_req` dropped after grant does not cancel the transaction; `slot_ok` still pulses.
- `refresh_en` = (state==IDLE) && `slot_req`==0 && !`downloading`, registered.
- Reset values:
  - state IDLE, `rr`=3 (so slot 1 wins first);
  - `read_req`, `slot_ok`, `timeout`, `refresh_en` all 0;
  - `slot_dout`, `sdram_addr`, `data_write` 0;
  - `sdram_rnw`=1, `sdram_wrmask`, `sdram_bank` 0.

## Timing
- Request seen in IDLE at cycle N → `read_req`=1 and fields valid at N+1.
- `sdram_ack` seen at cycle M → `read_req`=0 at M+1.
- `data_rdy` seen at cycle K → `slot_ok`/`slot_dout` valid at K+1 for exactly one cycle.
- Earliest next grant is at K+2, because IDLE is occupied for one cycle.
- A slot_0 request arriving while REQ or BUSY for another slot waits for completion; there is no preemption.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `jtframe_sdram_pkg`: state encoding (IDLE=0, REQ=1, BUSY=2) and the slot count constant (4).
- Sub-module `jtframe_sdram_rrpick`: combinational 3-way round-robin picker. Inputs are `req[3:1]` and `rr`; outputs are grant index and valid.
- The top level holds the FSM, field latches and watchdog.

## Test plan
- Single slot 2 read, addr 22'h1234, controller acks after 3 cycles and `data_rdy` 4 cycles later with 32'hDEADBEEF → `slot_ok`=4'b0100 for one cycle, `slot_dout`=32'hDEADBEEF.
- Slots 1, 2, 3 held high continuously, 6 transactions → grant order 1, 2, 3, 1, 2, 3.
- Slot 0 and slot 3 requesting, slot 3 currently in BUSY → slot 3 completes, then slot 0 is granted next, then slot 3 again.
- Slot 1 write, din 16'hA5A5, wrmask 2'b10 → `sdram_rnw`=0, `data_write`=16'hA5A5, `sdram_wrmask`=2'b10; `slot_dout` unchanged after `slot_ok`.
- `downloading` asserted in BUSY → IDLE next cycle, no `slot_ok`, `refresh_en`=0 while downloading; after deassert, the pending slot is regranted.
- `data_rdy` never arrives with TOUT=4 → `timeout`=1 after 15 BUSY cycles, FSM returns to IDLE, next request is serviced normally.
